// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the delay timer scheduler: FSM states, default sizes,
// and extraction of one requester's delay from the packed delay bus.
package delay_sched_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned MAX_CNT_W   = 32;
  localparam int unsigned MAX_BUS_W   = 8 * MAX_CNT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Caller zero-extends the bus to MAX_BUS_W and truncates the result to its CNT_W.
  function automatic logic [MAX_CNT_W-1:0] delay_slice(input logic [MAX_BUS_W-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned width);
    logic [MAX_BUS_W-1:0] sh;
    sh = bus >> (idx * width);
    return sh[MAX_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/delay_timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/delay_timer_scheduler.sv
// Shares one delay down-counter among NUM_REQ requesters: round-robin grant,
// load, count down, pulse done to the owner, then release.
module delay_timer_scheduler
  import delay_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_delay,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [CNT_W-1:0]   load_val;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign ptr_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  // A zero delay is promoted to one so every grant lasts at least one cycle.
  always_comb begin
    load_val = CNT_W'(delay_slice(MAX_BUS_W'(req_delay), 32'(arb_idx), CNT_W));
    if (load_val == '0)
      load_val = CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      count <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= RUN;
            busy  <= 1'b1;
            gnt   <= arb_gnt;
            owner <= arb_idx;
            count <= load_val;
          end
        end
        RUN: begin
          // Abort takes precedence over a completion on the same edge.
          if (!req[owner]) begin
            state <= IDLE;
            busy  <= 1'b0;
            gnt   <= '0;
            count <= '0;
            ptr   <= ptr_next;
          end else if (count == CNT_W'(1)) begin
            state       <= DONE;
            gnt         <= '0;
            count       <= '0;
            done[owner] <= 1'b1;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ptr   <= ptr_next;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          gnt   <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/delay_timer_scheduler.md
Name: delay_timer_scheduler

Overview:
- Shares one delay down-counter among NUM_REQ requesters.
- Each requester asks for a programmable delay. The scheduler grants requesters round-robin, runs the counter, and pulses that requester's done.
- Sits between the delay-timer datapath and the blocks that need timed waits (debounce, power-up sequencing, timeouts). It sequences the counter: load, run, complete, release.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 16, width of each delay value and of the internal counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req  input  NUM_REQ  level request per requester; held until done or deliberately dropped (abort).
- req_delay  input  NUM_REQ*CNT_W  packed delays; slice i = req_delay[i*CNT_W +: CNT_W]; sampled only in the grant cycle.
- gnt  output  NUM_REQ  one-hot (or zero) owner of the counter.
- done  output  NUM_REQ  one-cycle pulse to the owner when its delay expires.
- busy  output  1  high whenever state != IDLE.
- count  output  CNT_W  current counter value, for debug/observation.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, gnt=0, done=0, busy=0, count=0, rr pointer=0. Reset wins over every other event, including mid-RUN; no done is emitted for an in-flight delay.
- State machine: IDLE, RUN, DONE (encoded in the package enum).
- IDLE:
  - If any req bit is high at edge t, pick a winner with the round-robin arbiter: the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - At t+1: state=RUN, gnt=onehot(winner), count=req_delay[winner].
  - A delay of 0 loads as 1.
  - If no req is high, stay in IDLE.
- RUN:
  - count decrements by 1 per cycle. gnt stays stable.
  - When count==1 at an edge: next state=DONE, count becomes 0, gnt clears, and done[winner]=1 for exactly that one cycle.
  - Result: for delay D>=1, gnt is high for exactly D cycles (g..g+D-1), and done pulses in cycle g+D.
- DONE:
  - One cycle.
  - Pointer becomes winner+1 mod NUM_REQ.
  - Next state is IDLE. Arbitration restarts from IDLE, so back-to-back grants are separated by 2 cycles (DONE, IDLE).
- Abort: if req[winner] is low at any edge in RUN:
  - state goes to IDLE next cycle, with gnt=0, count=0, and no done.
  - Pointer advances past the winner as for a normal completion.
- Requests from other requesters during RUN are ignored until IDLE; they are never lost, because req is a held level.
- A requester that keeps req high after its done is re-eligible. However, the rotated pointer gives any other pending requester priority first.
- Invariants:
  - gnt is never multi-hot, and at most one done bit is high.
  - done is high only in the cycle immediately following the owner's last gnt cycle.
- The counter never underflows; count is 0 whenever gnt is 0.

Decomposition:
- Package delay_sched_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the default CNT_W/NUM_REQ localparams;
  - a function to extract the delay slice.
- One sub-module, rr_arbiter, parameterized by NUM_REQ:
  - inputs: req vector, pointer;
  - outputs: one-hot grant and winner index;
  - purely combinational.
- The FSM, counter and pointer register live in delay_timer_scheduler.

Test Plan:
- Single request: req[0]=1, delay=5 -> gnt[0] is high for 5 cycles, done[0] pulses once in the 6th cycle after grant, then busy drops 1 cycle later.
- Zero delay: req[2]=1, delay=0 -> behaves as delay 1: gnt[2] is high for 1 cycle, then the done[2] pulse follows.
- Round-robin fairness: all 4 reqs held high, delays 3/4/5/6 -> grant order 0,1,2,3,0; each done matches its delay; gnt is never multi-hot.
- Abort: req[1]=1, delay=10; drop req[1] after 4 gnt cycles -> gnt clears the next cycle, no done[1], count=0, IDLE.
- Reset mid-RUN: req[3]=1, delay=8; assert rst_n=0 at grant cycle 3 -> next cycle all outputs are 0 and no done pulse; after release, the pending req[3] is re-granted.
- Late arrival: req[0] is running (delay 6) and req[1] rises at cycle 2 -> req[1] is granted 2 cycles after done[0] (after the DONE and IDLE cycles), with count loaded from its own delay.
